// File: rtl/wb_scoreboard.sv
// Writeback scoreboard: ALU results win the RF write port, LSU results wait in a Depth-entry FIFO,
// RF write is registered (latency 1); LSU backpressure via lsu_ready_o, issue blocked via stall_o.
module wb_scoreboard #(
  parameter int DWidth   = 32,
  parameter int NumofReg = 32,
  parameter int Depth    = 4,
  parameter int AWidth   = $clog2(NumofReg)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  input  logic                issue_long_i,
  input  logic [AWidth-1:0]   issue_rd_i,
  input  logic [AWidth-1:0]   issue_rs1_i,
  input  logic [AWidth-1:0]   issue_rs2_i,
  output logic                stall_o,
  input  logic                alu_valid_i,
  input  logic [AWidth-1:0]   alu_rd_i,
  input  logic [DWidth-1:0]   alu_data_i,
  input  logic                lsu_valid_i,
  output logic                lsu_ready_o,
  input  logic [AWidth-1:0]   lsu_rd_i,
  input  logic [DWidth-1:0]   lsu_data_i,
  output logic                rf_write_en_o,
  output logic [AWidth-1:0]   rf_write_addr_o,
  output logic [DWidth-1:0]   rf_write_data_o,
  output logic [NumofReg-1:0] pending_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [AWidth-1:0]   rd_mem_q   [Depth];
  logic [DWidth-1:0]   data_mem_q [Depth];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [CntW-1:0]     count_q, count_d;
  logic [NumofReg-1:0] pend_q, pend_d;
  logic                rf_en_q, rf_en_d;
  logic [AWidth-1:0]   rf_addr_q, rf_addr_d;
  logic [DWidth-1:0]   rf_data_q, rf_data_d;

  logic                push, pop, sel, set_pend;
  logic [AWidth-1:0]   sel_rd;
  logic [DWidth-1:0]   sel_data;

  assign lsu_ready_o = (count_q < CntW'(Depth));
  assign push        = lsu_valid_i && lsu_ready_o;
  assign pop         = !alu_valid_i && (count_q != '0);
  assign stall_o     = issue_valid_i &&
                       (pend_q[issue_rs1_i] || pend_q[issue_rs2_i] || pend_q[issue_rd_i]);
  assign set_pend    = issue_valid_i && issue_long_i && !stall_o && (issue_rd_i != '0);

  always_comb begin
    sel      = alu_valid_i || pop;
    sel_rd   = alu_valid_i ? alu_rd_i   : rd_mem_q[rptr_q];
    sel_data = alu_valid_i ? alu_data_i : data_mem_q[rptr_q];
    rf_en_d   = sel && (sel_rd != '0);
    rf_addr_d = sel ? sel_rd   : rf_addr_q;
    rf_data_d = sel ? sel_data : rf_data_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);

    // Clear first so a same-cycle set on the same register wins.
    pend_d = pend_q;
    if (pop)      pend_d[rd_mem_q[rptr_q]] = 1'b0;
    if (set_pend) pend_d[issue_rd_i]       = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      pend_q    <= '0;
      rf_en_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q   <= count_d;
      pend_q    <= pend_d;
      rf_en_q   <= rf_en_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      rd_mem_q[wptr_q]   <= lsu_rd_i;
      data_mem_q[wptr_q] <= lsu_data_i;
    end
  end

  assign rf_write_en_o   = rf_en_q;
  assign rf_write_addr_o = rf_addr_q;
  assign rf_write_data_o = rf_data_q;
  assign pending_o       = pend_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i, issue_long_i;
  logic [4:0]  issue_rd_i, issue_rs1_i, issue_rs2_i;
  logic        stall_o;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i, lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic        rf_write_en_o;
  logic [4:0]  rf_write_addr_o;
  logic [31:0] rf_write_data_o;
  logic [31:0] pending_o;

  wb_scoreboard #(.DWidth(32), .NumofReg(32), .Depth(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_long_i(issue_long_i),
    .issue_rd_i(issue_rd_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .stall_o(stall_o),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .rf_write_en_o(rf_write_en_o), .rf_write_addr_o(rf_write_addr_o),
    .rf_write_data_o(rf_write_data_o), .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  // Reference model: buffered LSU results, pending set, last RF write.
  ent_t        m_q[$];
  logic [31:0] m_pend;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic mdl_stall();
    return issue_valid_i && (m_pend[issue_rs1_i] || m_pend[issue_rs2_i] || m_pend[issue_rd_i]);
  endfunction

  // Advance model by one clock using the inputs currently driven, then pass the edge.
  task automatic tick();
    ent_t w, e;
    logic sel, popd, rdy, stl;
    rdy = (m_q.size() < 4);
    stl = mdl_stall();
    if (rst_i) begin
      m_q.delete();
      m_pend = '0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
    end else begin
      sel = 1'b0; popd = 1'b0;
      w.rd = '0; w.d = '0;
      if (alu_valid_i) begin
        w.rd = alu_rd_i; w.d = alu_data_i; sel = 1'b1;
      end else if (m_q.size() > 0) begin
        w = m_q.pop_front(); sel = 1'b1; popd = 1'b1;
      end
      if (lsu_valid_i && rdy) begin
        e.rd = lsu_rd_i; e.d = lsu_data_i;
        m_q.push_back(e);
      end
      if (popd) m_pend[w.rd] = 1'b0;
      if (issue_valid_i && issue_long_i && !stl && issue_rd_i != 0) m_pend[issue_rd_i] = 1'b1;
      m_wen = sel && (w.rd != 0);
      if (sel) begin m_waddr = w.rd; m_wdata = w.d; end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle_inputs();
    issue_valid_i = 0; issue_long_i = 0; issue_rd_i = 0; issue_rs1_i = 0; issue_rs2_i = 0;
    alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
    lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; idle_inputs();
    tick(); tick();
    rst_i = 0;
    n_chk++; if (rf_write_en_o !== 1'b0) $display("FAIL reset_wen got=%0b exp=0", rf_write_en_o); else n_pass++;
    n_chk++; if (rf_write_addr_o !== 5'd0) $display("FAIL reset_waddr got=%0d exp=0", rf_write_addr_o); else n_pass++;
    n_chk++; if (rf_write_data_o !== 32'd0) $display("FAIL reset_wdata got=%h exp=0", rf_write_data_o); else n_pass++;
    n_chk++; if (pending_o !== 32'd0) $display("FAIL reset_pending got=%h exp=0", pending_o); else n_pass++;
    n_chk++; if (lsu_ready_o !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", lsu_ready_o); else n_pass++;
  endtask

  task automatic test_long_issue();
    issue_valid_i = 1; issue_long_i = 1; issue_rd_i = 5; issue_rs1_i = 1; issue_rs2_i = 2; #1;
    n_chk++; if (stall_o !== 1'b0) $display("FAIL long_stall got=%0b exp=0", stall_o); else n_pass++;
    tick();
    issue_valid_i = 0;
    n_chk++; if (pending_o[5] !== 1'b1) $display("FAIL long_pend_set got=%0b exp=1", pending_o[5]); else n_pass++;
    lsu_valid_i = 1; lsu_rd_i = 5; lsu_data_i = 32'hA5;
    tick();
    lsu_valid_i = 0;
    n_chk++; if (pending_o[5] !== 1'b1) $display("FAIL long_pend_hold got=%0b exp=1", pending_o[5]); else n_pass++;
    n_chk++; if (rf_write_en_o !== 1'b0) $display("FAIL long_early_wen got=%0b exp=0", rf_write_en_o); else n_pass++;
    tick();
    n_chk++; if (rf_write_en_o !== 1'b1) $display("FAIL long_wen got=%0b exp=1", rf_write_en_o); else n_pass++;
    n_chk++; if (rf_write_addr_o !== 5'd5) $display("FAIL long_waddr got=%0d exp=5", rf_write_addr_o); else n_pass++;
    n_chk++; if (rf_write_data_o !== 32'hA5) $display("FAIL long_wdata got=%h exp=a5", rf_write_data_o); else n_pass++;
    n_chk++; if (pending_o[5] !== 1'b0) $display("FAIL long_pend_clr got=%0b exp=0", pending_o[5]); else n_pass++;
    tick();
    n_chk++; if (rf_write_en_o !== 1'b0) $display("FAIL long_idle_wen got=%0b exp=0", rf_write_en_o); else n_pass++;
  endtask

  task automatic test_priority();
    alu_valid_i = 1; alu_rd_i = 3; alu_data_i = 32'h33;
    lsu_valid_i = 1; lsu_rd_i = 7; lsu_data_i = 32'h77;
    tick();
    alu_valid_i = 0; lsu_valid_i = 0;
    n_chk++; if (rf_write_en_o !== 1'b1 || rf_write_addr_o !== 5'd3 || rf_write_data_o !== 32'h33)
      $display("FAIL prio_alu got=%0b/%0d/%h exp=1/3/33", rf_write_en_o, rf_write_addr_o, rf_write_data_o); else n_pass++;
    tick();
    n_chk++; if (rf_write_en_o !== 1'b1 || rf_write_addr_o !== 5'd7 || rf_write_data_o !== 32'h77)
      $display("FAIL prio_lsu got=%0b/%0d/%h exp=1/7/77", rf_write_en_o, rf_write_addr_o, rf_write_data_o); else n_pass++;
    tick();
    n_chk++; if (rf_write_en_o !== 1'b0) $display("FAIL prio_empty_wen got=%0b exp=0", rf_write_en_o); else n_pass++;
    n_chk++; if (lsu_ready_o !== 1'b1) $display("FAIL prio_ready got=%0b exp=1", lsu_ready_o); else n_pass++;
  endtask

  task automatic test_full();
    logic [4:0]  r[5];
    logic [31:0] d[5];
    int got = 0;
    logic acc;
    for (int i = 0; i < 5; i++) begin
      r[i] = 5'($urandom_range(1, 31));
      d[i] = $urandom;
    end
    alu_valid_i = 1; alu_rd_i = 1; alu_data_i = $urandom;
    for (int i = 0; i < 4; i++) begin
      lsu_valid_i = 1; lsu_rd_i = r[i]; lsu_data_i = d[i];
      tick();
    end
    lsu_rd_i = r[4]; lsu_data_i = d[4]; #1;
    n_chk++; if (lsu_ready_o !== 1'b0) $display("FAIL full_ready got=%0b exp=0", lsu_ready_o); else n_pass++;
    tick(); tick();
    n_chk++; if (lsu_ready_o !== 1'b0) $display("FAIL full_held got=%0b exp=0", lsu_ready_o); else n_pass++;
    alu_valid_i = 0;
    for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
      acc = lsu_valid_i && lsu_ready_o;
      tick();
      if (acc) lsu_valid_i = 0;
      if (rf_write_en_o) begin
        n_chk++;
        if (rf_write_addr_o !== r[got] || rf_write_data_o !== d[got])
          $display("FAIL full_order%0d got=%0d/%h exp=%0d/%h", got, rf_write_addr_o, rf_write_data_o, r[got], d[got]);
        else n_pass++;
        got++;
      end
    end
    lsu_valid_i = 0;
    n_chk++; if (got !== 5) $display("FAIL full_drain_count got=%0d exp=5", got); else n_pass++;
    tick();
  endtask

  task automatic test_hazard();
    issue_valid_i = 1; issue_long_i = 1; issue_rd_i = 9; issue_rs1_i = 0; issue_rs2_i = 0;
    tick();
    n_chk++; if (pending_o[9] !== 1'b1) $display("FAIL haz_pend9 got=%0b exp=1", pending_o[9]); else n_pass++;
    issue_long_i = 0; issue_rd_i = 0; issue_rs1_i = 9; #1;
    n_chk++; if (stall_o !== 1'b1) $display("FAIL haz_rs1 got=%0b exp=1", stall_o); else n_pass++;
    issue_rs1_i = 0; issue_rs2_i = 9; #1;
    n_chk++; if (stall_o !== 1'b1) $display("FAIL haz_rs2 got=%0b exp=1", stall_o); else n_pass++;
    issue_rs2_i = 0; issue_rd_i = 9; #1;
    n_chk++; if (stall_o !== 1'b1) $display("FAIL haz_rd got=%0b exp=1", stall_o); else n_pass++;
    issue_rd_i = 0; #1;
    n_chk++; if (stall_o !== 1'b0) $display("FAIL haz_zero got=%0b exp=0", stall_o); else n_pass++;
    issue_long_i = 1; issue_rd_i = 12; issue_rs1_i = 9;
    tick();
    n_chk++; if (pending_o[12] !== 1'b0) $display("FAIL haz_stalled_set got=%0b exp=0", pending_o[12]); else n_pass++;
    issue_valid_i = 0; issue_long_i = 0; issue_rd_i = 0; issue_rs1_i = 0;
    lsu_valid_i = 1; lsu_rd_i = 9; lsu_data_i = 32'h99;
    tick();
    lsu_valid_i = 0;
    tick();
    n_chk++; if (pending_o[9] !== 1'b0) $display("FAIL haz_clear9 got=%0b exp=0", pending_o[9]); else n_pass++;
  endtask

  task automatic test_same_reg();
    lsu_valid_i = 1; lsu_rd_i = 4; lsu_data_i = 32'h44;
    tick();
    lsu_valid_i = 0;
    issue_valid_i = 1; issue_long_i = 1; issue_rd_i = 4; issue_rs1_i = 0; issue_rs2_i = 0; #1;
    n_chk++; if (stall_o !== 1'b0) $display("FAIL same_stall got=%0b exp=0", stall_o); else n_pass++;
    tick();
    issue_valid_i = 0; issue_long_i = 0; issue_rd_i = 0;
    n_chk++; if (pending_o[4] !== 1'b1) $display("FAIL same_pend4 got=%0b exp=1", pending_o[4]); else n_pass++;
    n_chk++; if (rf_write_en_o !== 1'b1 || rf_write_addr_o !== 5'd4)
      $display("FAIL same_write got=%0b/%0d exp=1/4", rf_write_en_o, rf_write_addr_o); else n_pass++;
    lsu_valid_i = 1;
    tick();
    lsu_valid_i = 0;
    tick();
    n_chk++; if (pending_o[4] !== 1'b0) $display("FAIL same_clear got=%0b exp=0", pending_o[4]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    issue_valid_i = 1; issue_long_i = 1; issue_rd_i = 10;
    tick();
    issue_valid_i = 0; issue_long_i = 0; issue_rd_i = 0;
    alu_valid_i = 1; alu_rd_i = 2; alu_data_i = 32'h22;
    for (int i = 0; i < 3; i++) begin
      lsu_valid_i = 1; lsu_rd_i = 5'(11 + i); lsu_data_i = 32'(i + 100);
      tick();
    end
    alu_valid_i = 0; lsu_rd_i = 14; rst_i = 1; #1;
    n_chk++; if (lsu_ready_o !== 1'b1) $display("FAIL rmid_ready_pre got=%0b exp=1", lsu_ready_o); else n_pass++;
    tick();
    rst_i = 0; lsu_valid_i = 0;
    n_chk++; if (pending_o !== 32'd0) $display("FAIL rmid_pending got=%h exp=0", pending_o); else n_pass++;
    n_chk++; if (lsu_ready_o !== 1'b1) $display("FAIL rmid_ready got=%0b exp=1", lsu_ready_o); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_chk++; if (rf_write_en_o !== 1'b0) $display("FAIL rmid_wen%0d got=%0b exp=0", i, rf_write_en_o); else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_i         = ($urandom_range(0, 99) == 0);
      issue_valid_i = $urandom_range(0, 1);
      issue_long_i  = $urandom_range(0, 1);
      issue_rd_i    = 5'($urandom_range(0, 7));
      issue_rs1_i   = 5'($urandom_range(0, 7));
      issue_rs2_i   = 5'($urandom_range(0, 7));
      alu_valid_i   = ($urandom_range(0, 3) == 0);
      alu_rd_i      = 5'($urandom_range(0, 7));
      alu_data_i    = $urandom;
      lsu_valid_i   = $urandom_range(0, 1);
      lsu_rd_i      = 5'($urandom_range(0, 7));
      lsu_data_i    = $urandom;
      #1;
      n_chk++; if (stall_o !== mdl_stall()) $display("FAIL rnd_stall c%0d got=%0b exp=%0b", i, stall_o, mdl_stall()); else n_pass++;
      n_chk++; if (lsu_ready_o !== (m_q.size() < 4)) $display("FAIL rnd_ready c%0d got=%0b exp=%0b", i, lsu_ready_o, m_q.size() < 4); else n_pass++;
      tick();
      n_chk++; if (rf_write_en_o !== m_wen) $display("FAIL rnd_wen c%0d got=%0b exp=%0b", i, rf_write_en_o, m_wen); else n_pass++;
      if (m_wen) begin
        n_chk++;
        if (rf_write_addr_o !== m_waddr || rf_write_data_o !== m_wdata)
          $display("FAIL rnd_wdat c%0d got=%0d/%h exp=%0d/%h", i, rf_write_addr_o, rf_write_data_o, m_waddr, m_wdata);
        else n_pass++;
      end
      n_chk++; if (pending_o !== m_pend) $display("FAIL rnd_pend c%0d got=%h exp=%h", i, pending_o, m_pend); else n_pass++;
    end
    rst_i = 0; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_long_issue();
    test_priority();
    test_full();
    test_hazard();
    test_same_reg();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_scoreboard.md
WB_SCOREBOARD -- requirements
Module: wb_scoreboard

Interface
REQ-001 The block SHALL have parameter DWidth, default 32, data width of the register file write port.
REQ-002 The block SHALL have parameter NumofReg, default 32, number of architectural registers; AWidth = clog2(NumofReg).
REQ-003 The block SHALL have parameter Depth, default 4, number of entries in the load-result buffer (power of two, at least 2).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports in this order:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have the following issue-side ports:
- issue_valid_i  input  1  an instruction is presented for issue.
- issue_long_i  input  1  the presented instruction produces its result via the LSU.
- issue_rd_i  input  AWidth  destination register.
- issue_rs1_i  input  AWidth  source 1.
- issue_rs2_i  input  AWidth  source 2.
- stall_o  output  1  the issue is blocked this cycle (combinational).
REQ-006 The block SHALL have the following ALU result ports:
- alu_valid_i  input  1  ALU result valid; always accepted.
- alu_rd_i  input  AWidth  ALU result destination.
- alu_data_i  input  DWidth  ALU result data.
REQ-007 The block SHALL have the following LSU result ports:
- lsu_valid_i  input  1  LSU result valid.
- lsu_ready_o  output  1  the buffer accepts an LSU result.
- lsu_rd_i  input  AWidth  LSU result destination.
- lsu_data_i  input  DWidth  LSU result data.
REQ-008 The block SHALL have the following register-file write and status ports:
- rf_write_en_o  output  1  registered write enable.
- rf_write_addr_o  output  AWidth  registered write address.
- rf_write_data_o  output  DWidth  registered write data.
- pending_o  output  NumofReg  pending bitmap; bit i set = register i awaits an LSU result.

Function
REQ-009 The block SHALL hold LSU results in a circular FIFO of Depth entries, with read/write pointers that wrap modulo Depth and an occupancy counter ranging 0..Depth.
REQ-010 lsu_ready_o SHALL equal (count < Depth), independent of a same-cycle pop; a push occurs when lsu_valid_i && lsu_ready_o.
REQ-011 lsu_valid_i while lsu_ready_o = 0 SHALL be ignored, with no state change and no data loss accounting.
REQ-012 Each cycle exactly one write source SHALL be selected, in priority order:
- alu_valid_i = 1: the ALU result is selected.
- else count > 0: the FIFO head is selected and popped.
- else: no write.
REQ-013 The selected write SHALL appear on rf_write_* one cycle after selection (registered, latency 1); rf_write_en_o SHALL be 0 in cycles with no selection.
REQ-014 A selected write with rd = 0 SHALL drive rf_write_en_o = 0, while the FIFO pop still occurs.
REQ-015 A push and a pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-016 stall_o SHALL equal issue_valid_i && (pending[rs1] || pending[rs2] || pending[rd]), where register 0 is never pending (RAW and WAW protection).
REQ-017 The pending bit of issue_rd_i SHALL be set when issue_valid_i && issue_long_i && !stall_o && issue_rd_i != 0.
REQ-018 The pending bit of a register SHALL be cleared on the edge at which an LSU FIFO entry for that register is popped.
REQ-019 When a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-020 ALU writes SHALL never modify pending bits.
REQ-021 pending_o SHALL be a direct register output, with bit 0 constant 0.

Reset
REQ-022 While rst_i is high at a rising edge, the block SHALL clear:
- count and both pointers to 0.
- all pending bits to 0.
- rf_write_en_o, rf_write_addr_o and rf_write_data_o to 0.
REQ-023 Reset asserted mid-operation SHALL discard all buffered LSU results without writing them, and rf_write_en_o SHALL be 0 in the cycle after the reset edge.
REQ-024 During the reset cycle, lsu_ready_o SHALL reflect the pre-reset count, and no push SHALL take effect.

Verification
REQ-025 Scenario, long issue: issue rd=5, long=1, then LSU returns rd=5 data=0xA5 with no ALU traffic. Required response:
- pending_o[5] = 1 until the pop edge.
- rf_write_en_o = 1, addr 5, data 0xA5 one cycle after the pop.
- pending_o[5] = 0 after the pop edge.
REQ-026 Scenario, priority: ALU rd=3 and LSU rd=7 are both valid for 1 cycle, with the FIFO empty. Required response:
- cycle+1 writes reg 3.
- cycle+2 writes reg 7.
- count returns to 0.
REQ-027 Scenario, full FIFO: ALU valid continuously, LSU pushes 5 results. Required response:
- lsu_ready_o = 0 after 4 pushes.
- the 5th push is held off until ALU valid drops.
- results drain in FIFO order across pointer wrap.
REQ-028 Scenario, hazards: pending[9] = 1. Required response:
- issue rs1=9 gives stall_o = 1.
- issue rd=9 gives stall_o = 1.
- issue rs1=0, rs2=0, rd=0 gives stall_o = 0.
REQ-029 Scenario, same-register set/clear: the pop of an rd=4 entry coincides with a new long issue of rd=4. Required response: pending_o[4] remains 1.
REQ-030 Scenario, reset mid-drain: 3 entries buffered, rst_i pulsed for 1 cycle. Required response:
- no further rf writes occur.
- count = 0, pending_o = 0.
- lsu_ready_o = 1.
